// File: rtl/card_deck_pkg.sv
// Shared deck definitions: card encoding, FSM states and the fill/shuffle helpers.
package card_deck_pkg;

  localparam int DECK_CARDS = 52;
  localparam int RANK_W     = 4;
  localparam int SUIT_W     = 2;

  localparam logic [RANK_W-1:0] RANK_ACE = 4'd1;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_READY   = 2'd2
  } deck_state_e;

  // Stored card: {suit, rank-1}
  typedef logic [SUIT_W+RANK_W-1:0] card_t;

  function automatic card_t fill_card(input logic [5:0] k);
    logic [SUIT_W-1:0] suit;
    logic [5:0]        base;
    if (k >= 6'd39) begin
      suit = 2'd3;
      base = 6'd39;
    end else if (k >= 6'd26) begin
      suit = 2'd2;
      base = 6'd26;
    end else if (k >= 6'd13) begin
      suit = 2'd1;
      base = 6'd13;
    end else begin
      suit = 2'd0;
      base = 6'd0;
    end
    return {suit, 4'(k - base)};
  endfunction

  // Smallest 2^n-1 covering i, so a masked draw is accepted at least half the time
  function automatic logic [5:0] shuffle_mask(input logic [5:0] i);
    if (i >= 6'd32) begin
      return 6'd63;
    end else if (i >= 6'd16) begin
      return 6'd31;
    end else if (i >= 6'd8) begin
      return 6'd15;
    end else if (i >= 6'd4) begin
      return 6'd7;
    end else if (i >= 6'd2) begin
      return 6'd3;
    end else begin
      return 6'd1;
    end
  endfunction

endpackage

// File: rtl/card_deck_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11, free-running; reused by other game blocks.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  // Right-shifting Galois step; an all-zero seed would lock up, hence SEED_EFF
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      q <= SEED_EFF;
    end else if (q[0]) begin
      q <= (q >> 1) ^ TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/card_deck.sv
// 52-card deck: fills a register array, Fisher-Yates shuffles it from a
// free-running LFSR, then deals one card per request with 1-cycle latency.
module card_deck
  import card_deck_pkg::*;
#(
  parameter int          DECK_SIZE = DECK_CARDS,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       shuffle_req,
  input  logic       deal_req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       busy
);

  localparam logic [5:0] LAST_IDX  = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);

  deck_state_e state_r, state_n;
  card_t       mem_r [DECK_SIZE];
  logic [5:0]  idx_r, idx_n, ptr_r, ptr_n, left_r, left_n;
  logic        valid_r, valid_n, empty_r, empty_n, busy_r, busy_n;
  logic [3:0]  rank_r, rank_n;
  logic [1:0]  suit_r, suit_n;
  logic [15:0] lfsr_q_s;
  logic [5:0]  cand_s;
  logic        accept_s, fill_we_s, swap_we_s, lfsr_unused_s;
  card_t       top_card_s;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .q        (lfsr_q_s)
  );

  assign cand_s        = lfsr_q_s[5:0] & shuffle_mask(idx_r);
  assign accept_s      = (cand_s <= idx_r);
  assign top_card_s    = mem_r[ptr_r];
  assign lfsr_unused_s = ^lfsr_q_s[15:6];

  // Next-state, counter and output-register logic; idx_r is the fill index k or shuffle index i
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    ptr_n     = ptr_r;
    left_n    = left_r;
    valid_n   = 1'b0;
    rank_n    = rank_r;
    suit_n    = suit_r;
    empty_n   = empty_r;
    busy_n    = busy_r;
    fill_we_s = 1'b0;
    swap_we_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        fill_we_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          state_n = ST_SHUFFLE;
          idx_n   = LAST_IDX;
        end else begin
          idx_n = idx_r + 6'd1;
        end
      end
      ST_SHUFFLE: begin
        if (accept_s) begin
          swap_we_s = 1'b1;
          if (idx_r == 6'd1) begin
            state_n = ST_READY;
            ptr_n   = 6'd0;
            left_n  = FULL_DECK;
            busy_n  = 1'b0;
            empty_n = 1'b0;
          end else begin
            idx_n = idx_r - 6'd1;
          end
        end else begin
          idx_n = idx_r;
        end
      end
      ST_READY: begin
        if (shuffle_req) begin
          state_n = ST_FILL;
          idx_n   = 6'd0;
          left_n  = 6'd0;
          busy_n  = 1'b1;
          empty_n = 1'b0;
        end else if (deal_req && (left_r != 6'd0)) begin
          valid_n = 1'b1;
          rank_n  = top_card_s[3:0] + RANK_ACE;
          suit_n  = top_card_s[5:4];
          ptr_n   = ptr_r + 6'd1;
          left_n  = left_r - 6'd1;
          empty_n = (left_r == 6'd1);
        end else begin
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_FILL;
        idx_n   = 6'd0;
        left_n  = 6'd0;
        busy_n  = 1'b1;
        empty_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_r <= ST_FILL;
      idx_r   <= 6'd0;
      ptr_r   <= 6'd0;
      left_r  <= 6'd0;
      valid_r <= 1'b0;
      rank_r  <= 4'd0;
      suit_r  <= 2'd0;
      empty_r <= 1'b0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      ptr_r   <= ptr_n;
      left_r  <= left_n;
      valid_r <= valid_n;
      rank_r  <= rank_n;
      suit_r  <= suit_n;
      empty_r <= empty_n;
      busy_r  <= busy_n;
    end
  end

  // Deck storage: sequential fill, then single-cycle swaps (r == i degenerates to a no-op)
  always_ff @(posedge CLOCK_50) begin
    if (reset_n && fill_we_s) begin
      mem_r[idx_r] <= fill_card(idx_r);
    end else if (reset_n && swap_we_s) begin
      mem_r[idx_r]  <= mem_r[cand_s];
      mem_r[cand_s] <= mem_r[idx_r];
    end
  end

  assign card_valid = valid_r;
  assign card_rank  = rank_r;
  assign card_suit  = suit_r;
  assign cards_left = left_r;
  assign deck_empty = empty_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_card_deck.sv
// Self-checking bench for card_deck: reference shuffle model, deal scoreboard and vector tables.
module tb_card_deck;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0, shuffle_req = 1'b0, deal_req = 1'b0, deal_req2 = 1'b0;
  logic       card_valid, card_valid2, deck_empty, deck_empty2, busy, busy2;
  logic [3:0] card_rank, card_rank2;
  logic [1:0] card_suit, card_suit2;
  logic [5:0] cards_left, cards_left2;

  always #10 clk = ~clk;

  card_deck #(.LFSR_SEED(16'hACE1)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .shuffle_req(shuffle_req), .deal_req(deal_req),
    .card_valid(card_valid), .card_rank(card_rank), .card_suit(card_suit),
    .cards_left(cards_left), .deck_empty(deck_empty), .busy(busy));

  card_deck #(.LFSR_SEED(16'hBEEF)) dut2 (
    .CLOCK_50(clk), .reset_n(reset_n), .shuffle_req(shuffle_req), .deal_req(deal_req2),
    .card_valid(card_valid2), .card_rank(card_rank2), .card_suit(card_suit2),
    .cards_left(cards_left2), .deck_empty(deck_empty2), .busy(busy2));

  typedef struct {
    bit shuffle;
    bit deal;
    bit e_valid;
    bit e_busy;
    int e_left;
    bit e_empty;
  } vec_t;

  int         checks = 0;
  int         fails = 0;
  logic [5:0] model_ace [52];
  logic [5:0] model_beef [52];
  int         s_ace, s_beef;
  logic [5:0] exp_q [$];
  bit         exp_valid = 1'b0;
  bit         order_known = 1'b0;
  int         deal_idx = 0;
  logic [5:0] dealt [52];
  int         n_dealt = 0;
  vec_t       tbl_empty [3];
  vec_t       tbl_fresh [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Reference fill + Fisher-Yates; also counts shuffle cycles (accepted + rejected draws)
  function automatic void build_model(input logic [15:0] seed, input bit which);
    logic [5:0]  m [52];
    logic [5:0]  t;
    logic [15:0] x;
    int          i, msk, r, cyc;
    for (int k = 0; k < 52; k++) m[k] = {2'(k / 13), 4'(k % 13)};
    x = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int k = 0; k < 52; k++) x = lfsr_next(x);
    i = 51;
    cyc = 0;
    while (i >= 1) begin
      msk = 1;
      while (msk < i) msk = (msk << 1) | 1;
      r = int'(x[5:0]) & msk;
      cyc++;
      if (r <= i) begin
        t = m[i]; m[i] = m[r]; m[r] = t;
        i--;
      end
      x = lfsr_next(x);
    end
    if (which) begin
      model_beef = m;
      s_beef = cyc;
    end else begin
      model_ace = m;
      s_ace = cyc;
    end
  endfunction

  task automatic tick();
    logic [5:0] e;
    @(posedge clk);
    #1;
    check("valid_timing", int'(card_valid), int'(exp_valid));
    if (card_valid) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("deal_rank", int'(card_rank), int'(e[3:0]) + 1);
        check("deal_suit", int'(card_suit), int'(e[5:4]));
      end
      if (n_dealt < 52) begin
        dealt[n_dealt] = {card_suit, 4'(card_rank - 4'd1)};
        n_dealt++;
      end
    end
    exp_valid = 1'b0;
  endtask

  task automatic drive(input bit shf, input bit dl, input bit expect_card);
    shuffle_req = shf;
    deal_req    = dl;
    exp_valid   = expect_card;
    if (expect_card) begin
      if (order_known) exp_q.push_back(model_ace[deal_idx]);
      deal_idx++;
    end
    tick();
    shuffle_req = 1'b0;
    deal_req    = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    drive(v.shuffle, v.deal, v.e_valid);
    check({tag, "_busy"}, int'(busy), int'(v.e_busy));
    check({tag, "_left"}, int'(cards_left), v.e_left);
    check({tag, "_empty"}, int'(deck_empty), int'(v.e_empty));
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (busy && cyc < 500) begin
      tick();
      cyc++;
    end
    check("ready_within_bound", int'(busy), 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    exp_q.delete();
    exp_valid = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_perm(input string name);
    bit seen [64];
    int cnt;
    cnt = 0;
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    for (int k = 0; k < n_dealt; k++) begin
      if (dealt[k][3:0] < 4'd13 && !seen[dealt[k]]) begin
        seen[dealt[k]] = 1'b1;
        cnt++;
      end
    end
    check(name, cnt, 52);
  endtask

  // 52 deals, one request every 3 cycles
  task automatic deal_all();
    n_dealt  = 0;
    deal_idx = 0;
    for (int k = 0; k < 52; k++) begin
      drive(1'b0, 1'b1, 1'b1);
      check("cards_left_step", int'(cards_left), 51 - k);
      tick();
      tick();
    end
    check_perm("deck_permutation");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, c2;
    bit same;
    logic [5:0] last;

    build_model(16'hACE1, 1'b0);
    build_model(16'hBEEF, 1'b1);

    //                shf   deal  valid busy  left empty
    tbl_empty[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b1};
    tbl_empty[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1};
    tbl_empty[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b1};
    tbl_fresh[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 51, 1'b0};
    tbl_fresh[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 50, 1'b0};
    tbl_fresh[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 50, 1'b0};
    tbl_fresh[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 0,  1'b0};
    tbl_fresh[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0};
    tbl_fresh[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 0,  1'b0};

    // Reset state and initial fill/shuffle
    reset_n = 1'b0;
    tick();
    check("rst_busy", int'(busy), 1);
    check("rst_cards_left", int'(cards_left), 0);
    check("rst_deck_empty", int'(deck_empty), 0);
    check("rst_card_valid", int'(card_valid), 0);
    check("rst_card_rank", int'(card_rank), 0);
    check("rst_card_suit", int'(card_suit), 0);
    reset_n = 1'b1;
    wait_ready(cyc);
    check("busy_at_least_103", int'(cyc >= 103), 1);
    check("busy_within_400", int'(cyc <= 400), 1);
    check("busy_cycles", cyc, 52 + s_ace);
    check("ready_cards_left", int'(cards_left), 52);
    check("ready_deck_empty", int'(deck_empty), 0);

    // Full deal against the reference order
    order_known = 1'b1;
    deal_all();

    // Empty deck: requests ignored, last card held
    last = model_ace[51];
    for (int k = 0; k < 3; k++) apply_vec(tbl_empty[k], "empty");
    check("hold_rank", int'(card_rank), int'(last[3:0]) + 1);
    check("hold_suit", int'(card_suit), int'(last[5:4]));

    // Second seed produces its own order
    c2 = 0;
    while (busy2 && c2 < 500) begin
      tick();
      c2++;
    end
    check("dut2_ready", int'(busy2), 0);
    same = 1'b1;
    for (int k = 0; k < 5; k++) begin
      deal_req2 = 1'b1;
      tick();
      deal_req2 = 1'b0;
      check("dut2_valid", int'(card_valid2), 1);
      check("dut2_rank", int'(card_rank2), int'(model_beef[k][3:0]) + 1);
      check("dut2_suit", int'(card_suit2), int'(model_beef[k][5:4]));
      if ({card_suit2, 4'(card_rank2 - 4'd1)} != model_ace[k]) same = 1'b0;
      tick();
    end
    check("seed_changes_first5", int'(same), 0);

    // shuffle_req mid-shuffle has no effect
    pulse_reset();
    repeat (70) tick();
    shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    check("busy_after_mid_shuffle_req", int'(busy), 1);
    wait_ready(cyc);
    check("mid_shuffle_req_cycles", 71 + cyc, 52 + s_ace);
    order_known = 1'b1;
    deal_all();

    // Reset mid-shuffle restarts and reproduces the fresh order
    pulse_reset();
    repeat (80) tick();
    pulse_reset();
    check("mid_reset_busy", int'(busy), 1);
    check("mid_reset_left", int'(cards_left), 0);
    wait_ready(cyc);
    check("mid_reset_cycles", cyc, 52 + s_ace);
    deal_idx    = 0;
    order_known = 1'b1;
    for (int k = 0; k < 6; k++) apply_vec(tbl_fresh[k], "fresh");
    wait_ready(cyc);
    check("reshuffle_cards_left", int'(cards_left), 52);
    check("reshuffle_deck_empty", int'(deck_empty), 0);
    order_known = 1'b0;
    deal_all();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
